// File: rtl/window_accum.sv
// window_accum: sums each burst of consecutive valid samples into a signed total and count,
// presents the result on a valid/ready register and flags results lost to back-pressure.
module window_accum #(
   parameter int data_width = 32,
   parameter int cnt_width  = 9,
   parameter int acc_width  = data_width + cnt_width,
   parameter int min_len    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [data_width-1:0] data_in,
   input  logic                  data_in_valid,
   output logic [acc_width-1:0]  sum_out,
   output logic [cnt_width-1:0]  sum_cnt,
   output logic                  sum_valid,
   input  logic                  sum_ready,
   output logic                  drop_err,
   input  logic                  err_clr
);

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic [cnt_width-1:0] max_cnt  = '1;
   localparam logic [cnt_width-1:0] last_cnt = max_cnt - cnt_width'(1);
   localparam logic [cnt_width-1:0] min_cnt  = cnt_width'(min_len);

   state_t                 state, next_state;
   logic [acc_width-1:0]   acc, acc_next;
   logic [cnt_width-1:0]   cnt, cnt_next;
   logic [acc_width-1:0]   sample_ext;
   logic [acc_width-1:0]   res_sum;
   logic [cnt_width-1:0]   res_cnt;
   logic                   res_fire;
   logic                   emit, reg_free, load, drop;

   assign sample_ext = {{(acc_width-data_width){data_in[data_width-1]}}, data_in};

   always_comb begin
      next_state = state;
      acc_next   = acc;
      cnt_next   = cnt;
      res_fire   = 1'b0;
      res_sum    = acc;
      res_cnt    = cnt;
      case (state)
         IDLE: begin
            if (data_in_valid) begin
               acc_next   = sample_ext;
               cnt_next   = cnt_width'(1);
               next_state = ACCUM;
            end
         end
         ACCUM: begin
            if (data_in_valid && cnt == last_cnt) begin
               // Counter would hit its ceiling: close the burst including this sample.
               res_fire   = 1'b1;
               res_sum    = acc + sample_ext;
               res_cnt    = max_cnt;
               acc_next   = '0;
               cnt_next   = '0;
               next_state = IDLE;
            end else if (data_in_valid) begin
               acc_next = acc + sample_ext;
               cnt_next = cnt + cnt_width'(1);
            end else begin
               res_fire   = 1'b1;
               acc_next   = '0;
               cnt_next   = '0;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign emit     = res_fire && (res_cnt >= min_cnt);
   assign reg_free = !sum_valid || sum_ready;
   assign load     = emit && reg_free;
   assign drop     = emit && !reg_free;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= next_state;
         acc   <= acc_next;
         cnt   <= cnt_next;
      end
   end

   // A new result may replace the held one on the same edge it is handed off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_out   <= '0;
         sum_cnt   <= '0;
         sum_valid <= 1'b0;
      end else if (load) begin
         sum_out   <= res_sum;
         sum_cnt   <= res_cnt;
         sum_valid <= 1'b1;
      end else if (sum_valid && sum_ready) begin
         sum_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_err <= 1'b0;
      else if (drop)
         drop_err <= 1'b1;
      else if (err_clr)
         drop_err <= 1'b0;
   end

endmodule

// File: tb/tb_window_accum.sv
// tb_window_accum: two instances (min_len 1 and 4) on shared inputs, checked by a
// burst-level reference model feeding per-instance expected-result queues.
module tb_window_accum;

   localparam int DW      = 32;
   localparam int CW      = 9;
   localparam int AW      = DW + CW;
   localparam int MAX_LEN = (1 << CW) - 1;
   localparam int MIN1    = 4;

   typedef struct {
      longint sum;
      int     cnt;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic          sum_ready = 1'b1;
   logic          err_clr = 1'b0;

   logic [AW-1:0] sum_out_w   [2];
   logic [CW-1:0] sum_cnt_w   [2];
   logic          sum_valid_w [2];
   logic          drop_err_w  [2];

   int tests = 0;
   int failures = 0;

   longint burst [$];
   res_t   exp_q [2][$];
   bit     held [2];
   bit     derr [2];
   bit     closing;
   longint m_sum;
   int     m_cnt;

   always #5 clk = ~clk;

   window_accum #(.data_width(DW), .cnt_width(CW), .min_len(1)) dut0 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .sum_out(sum_out_w[0]), .sum_cnt(sum_cnt_w[0]), .sum_valid(sum_valid_w[0]),
      .sum_ready(sum_ready), .drop_err(drop_err_w[0]), .err_clr(err_clr));

   window_accum #(.data_width(DW), .cnt_width(CW), .min_len(MIN1)) dut1 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .sum_out(sum_out_w[1]), .sum_cnt(sum_cnt_w[1]), .sum_valid(sum_valid_w[1]),
      .sum_ready(sum_ready), .drop_err(drop_err_w[1]), .err_clr(err_clr));

   function automatic int minLenOf(input int k);
      return (k == 0) ? 1 : MIN1;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [DW-1:0] d, input logic v, input logic r,
                                input logic c);
      data_in       = d;
      data_in_valid = v;
      sum_ready     = r;
      err_clr       = c;
      @(posedge clk);
      #1;
   endtask

   task automatic sendBurst(input logic [DW-1:0] d, input int n, input logic r);
      for (int i = 0; i < n; i++) applyStimulus(d, 1'b1, r, 1'b0);
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, r, 1'b0);
   endtask

   // Reference model: a burst is just the list of samples seen; it closes when valid
   // drops or the list reaches the maximum length, and its result is the plain sum.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         burst.delete();
         for (int k = 0; k < 2; k++) begin
            held[k] = 1'b0;
            derr[k] = 1'b0;
            exp_q[k].delete();
         end
      end else begin
         closing = 1'b0;
         m_sum   = 0;
         m_cnt   = 0;
         if (data_in_valid) begin
            burst.push_back(longint'($signed(data_in)));
            closing = (burst.size() == MAX_LEN);
         end else begin
            closing = (burst.size() != 0);
         end
         if (closing) begin
            foreach (burst[i]) m_sum += burst[i];
            m_cnt = burst.size();
            burst.delete();
         end
         for (int k = 0; k < 2; k++) begin
            bit dropped;
            dropped = 1'b0;
            if (closing && m_cnt >= minLenOf(k)) begin
               if (!held[k] || sum_ready) begin
                  exp_q[k].push_back('{m_sum, m_cnt});
                  held[k] = 1'b1;
               end else begin
                  dropped = 1'b1;
               end
            end else if (held[k] && sum_ready) begin
               held[k] = 1'b0;
            end
            if (dropped)
               derr[k] = 1'b1;
            else if (err_clr)
               derr[k] = 1'b0;
         end
      end
   end

   // Monitor: pops the expected result whenever a handshake is about to happen.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            res_t r;
            checkOutput($sformatf("sum_valid%0d", k), longint'(sum_valid_w[k]), longint'(held[k]));
            checkOutput($sformatf("drop_err%0d", k), longint'(drop_err_w[k]), longint'(derr[k]));
            if (sum_valid_w[k] && sum_ready) begin
               if (exp_q[k].size() == 0) begin
                  tests++;
                  failures++;
                  $display("[TB] FAIL unexpected_result%0d: got sum %0d cnt %0d, expected none",
                           k, $signed(sum_out_w[k]), sum_cnt_w[k]);
               end else begin
                  r = exp_q[k].pop_front();
                  checkOutput($sformatf("sum_out%0d", k), longint'($signed(sum_out_w[k])), r.sum);
                  checkOutput($sformatf("sum_cnt%0d", k), longint'(sum_cnt_w[k]), longint'(r.cnt));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         checkOutput("reset_sum_out", longint'(sum_out_w[k]), 0);
         checkOutput("reset_sum_cnt", longint'(sum_cnt_w[k]), 0);
         checkOutput("reset_sum_valid", longint'(sum_valid_w[k]), 0);
         checkOutput("reset_drop_err", longint'(drop_err_w[k]), 0);
      end
      rst = 1'b0;
      idle(2, 1'b1);

      applyStimulus(32'd10, 1'b1, 1'b1, 1'b0);
      applyStimulus(32'd20, 1'b1, 1'b1, 1'b0);
      applyStimulus(-32'sd5, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);

      sendBurst(32'h7FFF_FFFF, 200, 1'b1);
      idle(2, 1'b1);
      sendBurst(32'h8000_0000, 200, 1'b1);
      idle(2, 1'b1);

      sendBurst(32'd1, 512, 1'b1);
      idle(3, 1'b1);

      applyStimulus(32'd2, 1'b1, 1'b0, 1'b0);
      applyStimulus(32'd3, 1'b1, 1'b0, 1'b0);
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      applyStimulus(32'd7, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b0);
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b0);
      idle(3, 1'b1);

      sendBurst(32'd1, 3, 1'b1);
      idle(1, 1'b1);
      sendBurst(32'd1, 4, 1'b1);
      idle(3, 1'b1);

      // Held result must be replaced seamlessly when a burst closes during the handshake.
      sendBurst(32'd9, 5, 1'b0);
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      sendBurst(32'd4, 6, 1'b0);
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);

      sendBurst(32'd3, 5, 1'b1);
      rst = 1'b1;
      data_in_valid = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checkOutput("midreset_sum_out", longint'(sum_out_w[k]), 0);
         checkOutput("midreset_sum_cnt", longint'(sum_cnt_w[k]), 0);
         checkOutput("midreset_sum_valid", longint'(sum_valid_w[k]), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      sendBurst(32'd1, 2, 1'b1);
      idle(3, 1'b1);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 19) == 0));
      end

      for (int i = 0; i < 50 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++)
         idle(1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         if (exp_q[k].size() != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL drain%0d: %0d results never presented, expected 0",
                     k, exp_q[k].size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
